window_gen_3x3: RTL and testbench



---
 rtl/window_gen_3x3_if.sv | 24 ++
 rtl/window_gen_3x3.sv | 136 +++++++++++++
 tb/tb_window_gen_3x3.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out signal bundle for window_gen_3x3.
// master drives pixels and start; slave is the window generator.
interface window_gen_3x3_if #(
   parameter int unsigned cell_bit = 8
);
   logic                  start;
   logic [cell_bit-1:0]   in_pixel;
   logic                  in_valid;
   logic [cell_bit*9-1:0] out_window;
   logic                  out_en;
   logic                  out_last;
   logic                  frame_done;
   logic                  busy;

   modport master (
      output start, in_pixel, in_valid,
      input  out_window, out_en, out_last, frame_done, busy
   );

   modport slave (
      input  start, in_pixel, in_valid,
      output out_window, out_en, out_last, frame_done, busy
   );
endinterface

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to packed 3x3 sliding windows, using two W-deep line buffers
// and a 3x3 register window; a small FSM frames one W*H image per start.
module window_gen_3x3 #(
   parameter int unsigned cell_bit   = 8,
   parameter int unsigned img_width  = 8,
   parameter int unsigned img_height = 8,
   parameter int unsigned cnt_bit    = 4
) (
   input logic               clk,
   input logic               reset,
   window_gen_3x3_if.slave   bus_io
);
   localparam int unsigned        LbAw    = $clog2(img_width);
   localparam logic [cnt_bit-1:0] ColLast = cnt_bit'(img_width - 1);
   localparam logic [cnt_bit-1:0] RowLast = cnt_bit'(img_height - 1);
   localparam logic [cnt_bit-1:0] CntTwo  = cnt_bit'(2);
   localparam logic [cnt_bit-1:0] CntOne  = cnt_bit'(1);

   typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

   state_e                state_q, state_d;
   logic [cnt_bit-1:0]    col_q, col_d;
   logic [cnt_bit-1:0]    row_q, row_d;
   logic [cell_bit-1:0]   win_q [9];
   logic [cell_bit-1:0]   win_d [9];
   logic [cell_bit-1:0]   lb0_q [img_width];
   logic [cell_bit-1:0]   lb1_q [img_width];
   logic [cell_bit*9-1:0] out_window_q, out_window_d;
   logic                  out_en_q, out_en_d;
   logic                  out_last_q, out_last_d;

   logic                  accept;
   logic                  last_pix;
   logic                  emit;
   logic [LbAw-1:0]       lb_idx;
   logic [cell_bit-1:0]   lb0_out;
   logic [cell_bit-1:0]   lb1_out;

   // A pixel presented together with start is dropped: the frame begins on the next valid.
   assign accept   = (state_q == StActive) && bus_io.in_valid && !bus_io.start;
   assign last_pix = (row_q == RowLast) && (col_q == ColLast);
   assign emit     = accept && (row_q >= CntTwo) && (col_q >= CntTwo);

   assign lb_idx  = col_q[LbAw-1:0];
   assign lb0_out = lb0_q[lb_idx];
   assign lb1_out = lb1_q[lb_idx];

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      if (bus_io.start) begin
         state_d = StActive;
         col_d   = '0;
         row_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: state_d = StIdle;
            StActive: begin
               if (accept) begin
                  if (col_q == ColLast) begin
                     col_d = '0;
                     row_d = last_pix ? '0 : row_q + CntOne;
                  end else begin
                     col_d = col_q + CntOne;
                  end
                  if (last_pix) begin
                     state_d = StDone;
                  end
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // start also clears the output strobes, so an aborted frame never leaks a window.
   assign out_en_d   = emit;
   assign out_last_d = emit && last_pix;

   always_comb begin
      win_d        = win_q;
      out_window_d = out_window_q;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r*3]     = win_q[r*3+1];
            win_d[r*3 + 1] = win_q[r*3+2];
         end
         win_d[2] = lb1_out;
         win_d[5] = lb0_out;
         win_d[8] = bus_io.in_pixel;
      end
      if (emit) begin
         for (int k = 0; k < 9; k++) begin
            out_window_d[cell_bit*k +: cell_bit] = win_d[k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         col_q        <= '0;
         row_q        <= '0;
         out_window_q <= '0;
         out_en_q     <= 1'b0;
         out_last_q   <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         out_window_q <= out_window_d;
         out_en_q     <= out_en_d;
         out_last_q   <= out_last_d;
         win_q        <= win_d;
      end
   end

   // Line buffers are never cleared; the row/col counters decide when their data is live.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_q[lb_idx] <= bus_io.in_pixel;
         lb1_q[lb_idx] <= lb0_out;
      end
   end

   assign bus_io.out_window = out_window_q;
   assign bus_io.out_en     = out_en_q;
   assign bus_io.out_last   = out_last_q;
   assign bus_io.frame_done = (state_q == StDone);
   assign bus_io.busy       = (state_q == StActive);
endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3: three instances (4x4, 5x3, 8x8) driven one at a time;
// expected windows are built from a pixel-grid model and must appear exactly one cycle later.
module tb_window_gen_3x3;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        start_v [3];
   logic        valid_v [3];
   logic [7:0]  pix_v   [3];
   logic        en_a    [3];
   logic        last_a  [3];
   logic        done_a  [3];
   logic        busy_a  [3];
   logic [71:0] win_a   [3];

   window_gen_3x3_if #(.cell_bit(8)) bus0 ();
   window_gen_3x3_if #(.cell_bit(8)) bus1 ();
   window_gen_3x3_if #(.cell_bit(8)) bus2 ();

   assign bus0.start = start_v[0];  assign bus0.in_valid = valid_v[0];  assign bus0.in_pixel = pix_v[0];
   assign bus1.start = start_v[1];  assign bus1.in_valid = valid_v[1];  assign bus1.in_pixel = pix_v[1];
   assign bus2.start = start_v[2];  assign bus2.in_valid = valid_v[2];  assign bus2.in_pixel = pix_v[2];
   assign en_a[0] = bus0.out_en;  assign last_a[0] = bus0.out_last;  assign done_a[0] = bus0.frame_done;
   assign en_a[1] = bus1.out_en;  assign last_a[1] = bus1.out_last;  assign done_a[1] = bus1.frame_done;
   assign en_a[2] = bus2.out_en;  assign last_a[2] = bus2.out_last;  assign done_a[2] = bus2.frame_done;
   assign busy_a[0] = bus0.busy;  assign win_a[0] = bus0.out_window;
   assign busy_a[1] = bus1.busy;  assign win_a[1] = bus1.out_window;
   assign busy_a[2] = bus2.busy;  assign win_a[2] = bus2.out_window;

   window_gen_3x3 #(.cell_bit(8), .img_width(4), .img_height(4), .cnt_bit(4)) u_dut_4x4 (
      .clk(clk), .reset(reset), .bus_io(bus0)
   );
   window_gen_3x3 #(.cell_bit(8), .img_width(5), .img_height(3), .cnt_bit(4)) u_dut_5x3 (
      .clk(clk), .reset(reset), .bus_io(bus1)
   );
   window_gen_3x3 #(.cell_bit(8), .img_width(8), .img_height(8), .cnt_bit(4)) u_dut_8x8 (
      .clk(clk), .reset(reset), .bus_io(bus2)
   );

   typedef struct {
      int          id;
      longint      due;
      logic [71:0] win;
      logic        last;
   } exp_t;

   exp_t        sb_q [$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail = 0;
   longint      cyc = 0;
   int          m_row [3];
   int          m_col [3];
   bit          m_active [3];
   int          pix_m [3][8][8];
   int          win_cnt [3];
   logic [71:0] first_win [3];
   logic [71:0] last_win [3];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int w_of(input int i);
      return (i == 0) ? 4 : (i == 1) ? 5 : 8;
   endfunction

   function automatic int h_of(input int i);
      return (i == 0) ? 4 : (i == 1) ? 3 : 8;
   endfunction

   function automatic logic [71:0] win9(input int a0, input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6, input int a7,
                                        input int a8);
      return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_start(input int i, input bit with_valid, input int px);
      start_v[i]  = 1'b1;
      valid_v[i]  = with_valid;
      pix_v[i]    = 8'(px);
      m_active[i] = 1'b1;
      m_row[i]    = 0;
      m_col[i]    = 0;
      tick();
      start_v[i] = 1'b0;
      valid_v[i] = 1'b0;
   endtask

   task automatic send(input int i, input int px);
      exp_t e;
      int   w;
      int   h;
      w = w_of(i);
      h = h_of(i);
      valid_v[i] = 1'b1;
      pix_v[i]   = 8'(px);
      if (m_active[i]) begin
         pix_m[i][m_row[i]][m_col[i]] = px;
         if (m_row[i] >= 2 && m_col[i] >= 2) begin
            e.id   = i;
            e.due  = cyc + 1;
            e.last = (m_row[i] == h - 1) && (m_col[i] == w - 1);
            for (int k = 0; k < 9; k++)
               e.win[8*k +: 8] = 8'(pix_m[i][m_row[i] - 2 + k / 3][m_col[i] - 2 + k % 3]);
            sb_q.push_back(e);
         end
         if (m_row[i] == h - 1 && m_col[i] == w - 1) begin
            m_active[i] = 1'b0;
         end else if (m_col[i] == w - 1) begin
            m_col[i] = 0;
            m_row[i]++;
         end else begin
            m_col[i]++;
         end
      end
      tick();
      valid_v[i] = 1'b0;
   endtask

   task automatic run_frame(input int i, input int base, input bit stall, input bit start_valid);
      do_start(i, start_valid, 8'hee);
      win_cnt[i] = 0;
      check("busy_active", busy_a[i], 1);
      for (int p = 0; p < w_of(i) * h_of(i); p++) begin
         send(i, base + p);
         if (stall) begin
            idle(1);
            if (win_cnt[i] > 0) check("hold", win_a[i], last_win[i]);
         end
      end
      idle(3);
      check("count", win_cnt[i], (w_of(i) - 2) * (h_of(i) - 2));
      check("busy_idle", busy_a[i], 0);
   endtask

   // Any output strobe not matched by a scoreboard entry due this very cycle is a failure.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (sb_q.size() > 0 && sb_q[0].id == i && sb_q[0].due == cyc) begin
            mon_e = sb_q.pop_front();
            check("out_en", en_a[i], 1);
            check("window", win_a[i], mon_e.win);
            check("out_last", last_a[i], mon_e.last);
            check("frame_done", done_a[i], mon_e.last);
            if (mon_e.last) check("busy_at_done", busy_a[i], 0);
            if (win_cnt[i] == 0) first_win[i] = win_a[i];
            last_win[i] = win_a[i];
            win_cnt[i]++;
         end else if (en_a[i] || last_a[i] || done_a[i]) begin
            check("spurious", {en_a[i], last_a[i], done_a[i]}, 0);
         end
      end
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0; valid_v[i] = 1'b0; pix_v[i] = '0;
         m_active[i] = 1'b0; m_row[i] = 0; m_col[i] = 0; win_cnt[i] = 0;
         first_win[i] = '0; last_win[i] = '0;
      end
      #1 reset = 1'b0;
      idle(3);
      for (int i = 0; i < 3; i++) begin
         check("rst_en", en_a[i], 0);
         check("rst_busy", busy_a[i], 0);
         check("rst_win", win_a[i], 0);
         check("rst_done", done_a[i], 0);
      end
      reset = 1'b1;
      idle(2);

      // basic 4x4 frame
      run_frame(0, 1, 1'b0, 1'b0);
      check("basic_first", first_win[0], win9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      check("basic_last", last_win[0], win9(6, 7, 8, 10, 11, 12, 14, 15, 16));

      // same frame with alternate-cycle stalls
      run_frame(0, 1, 1'b1, 1'b0);
      check("stall_first", first_win[0], win9(1, 2, 3, 5, 6, 7, 9, 10, 11));

      // 5x3: no windows across row wrap
      run_frame(1, 1, 1'b0, 1'b0);
      check("w5_last", last_win[1], win9(3, 4, 5, 8, 9, 10, 13, 14, 15));

      // restart mid-frame; pixel given with start is dropped
      do_start(0, 1'b0, 0);
      for (int p = 1; p <= 11; p++) send(0, p);
      run_frame(0, 1, 1'b0, 1'b1);
      check("restart_first", first_win[0], win9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      check("restart_last", last_win[0], win9(6, 7, 8, 10, 11, 12, 14, 15, 16));

      // async reset between edges while a window is on the output
      do_start(0, 1'b0, 0);
      for (int p = 1; p <= 11; p++) send(0, p);
      check("pre_rst_en", en_a[0], 1);
      #1 reset = 1'b0;
      #1;
      check("arst_en", en_a[0], 0);
      check("arst_win", win_a[0], 0);
      check("arst_busy", busy_a[0], 0);
      check("arst_last", last_a[0], 0);
      sb_q.delete();
      for (int i = 0; i < 3; i++) m_active[i] = 1'b0;
      tick();
      reset = 1'b1;
      for (int p = 0; p < 20; p++) send(0, 50 + p);
      idle(2);
      run_frame(0, 1, 1'b0, 1'b0);
      check("post_rst_first", first_win[0], win9(1, 2, 3, 5, 6, 7, 9, 10, 11));

      // default 8x8 frame
      run_frame(2, 0, 1'b0, 1'b0);
      check("w8_first", first_win[2], win9(0, 1, 2, 8, 9, 10, 16, 17, 18));

      idle(3);
      check("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
